xc20xx_clb_cfg_loader: RTL
==========================

XC20XX_CLB_CFG_LOADER -- requirements
Module: xc20xx_clb_cfg_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter SYNC_WORD SHALL default to 8'hF2 and set the frame sync pattern.
REQ-003 Parameter FRAME_BITS SHALL default to 26 and set the number of config payload bits; it is fixed by the package.
REQ-004 Port K SHALL be a 1-bit input: the clock; all state updates on rising edge.
REQ-005 Port R SHALL be a 1-bit input: asynchronous active-high reset.
REQ-006 Port DIN SHALL be a 1-bit input: serial config data, MSB first.
REQ-007 Port DVALID SHALL be a 1-bit input: DIN is accepted only in cycles where DVALID=1.
REQ-008 Outputs F_INIT[7:0], G_INIT[7:0], MUX_FG[0], S_IN[1:0], CLK_IN[1:0], CLK_POL[1:0], MODE[0] and R_IN[1:0] SHALL carry the decoded CLB configuration.
REQ-009 Outputs CFG_VALID, CFG_DONE, CFG_ERR and BUSY SHALL each be 1 bit: config held since reset; one-cycle accept pulse; one-cycle reject pulse; frame in progress.

Function
REQ-010 Frame format SHALL be SYNC_WORD (8 bits), then payload F_INIT, G_INIT, MUX_FG, S_IN, CLK_IN, CLK_POL, MODE, R_IN (26 bits), then 1 parity bit, each field MSB first.
REQ-011 Encodings SHALL be: S_IN 00=A, 01=F, 10=NONE; CLK_IN 00=K, 01=C, 10=G; CLK_POL 00=POSITIVE, 01=NEGATIVE, 10=NONE; MODE 0=DFF, 1=DLATCH; R_IN 00=D, 01=F, 10=NONE; code 11 is reserved in every 2-bit field.
REQ-012 The FSM SHALL have states HUNT, LOAD and CHECK.
REQ-013 In HUNT, accepted bits SHALL shift into an 8-bit window; when the window equals SYNC_WORD, the next state SHALL be LOAD with the bit counter cleared to 0.
REQ-014 In LOAD, each accepted bit SHALL shift into a 26-bit payload register and increment the counter; after bit 25, the next accepted bit SHALL be latched as parity and the next state SHALL be CHECK.
REQ-015 CHECK SHALL last exactly one cycle and return to HUNT with the sync window cleared.
REQ-016 CHECK SHALL accept the frame when the XOR of the 26 payload bits and the parity bit is 0 and no 2-bit field holds 11; otherwise it SHALL reject.
REQ-017 On accept, the config outputs SHALL update on the edge ending CHECK, with CFG_DONE=1 for that one cycle and CFG_VALID set to 1.
REQ-018 On reject, the config outputs and CFG_VALID SHALL be unchanged, and CFG_ERR=1 for one cycle.
REQ-019 Latency SHALL be 2 clock edges from the edge that accepts the parity bit until the outputs and pulse are visible.
REQ-020 BUSY SHALL be 1 in LOAD and CHECK and 0 in HUNT.
REQ-021 DVALID=0 SHALL stall HUNT and LOAD with no state, counter or shift change; CHECK SHALL proceed regardless of DVALID.
REQ-022 DIN accepted during CHECK SHALL be discarded and SHALL NOT enter the sync window.
REQ-023 A SYNC_WORD pattern appearing inside the payload SHALL NOT restart the frame.
REQ-024 Back-to-back frames SHALL be supported, with the next frame's sync bits accepted starting in the cycle after CHECK.

Reset
REQ-025 While R=1, the FSM SHALL be in HUNT; the counter, sync window and payload SHALL be 0.
REQ-026 While R=1, all config outputs SHALL be 0 (the A/K/POSITIVE/DFF/D defaults), and CFG_VALID, CFG_DONE, CFG_ERR and BUSY SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no CFG_DONE or CFG_ERR pulse.

Structure
REQ-028 Package xc20xx_cfg_pkg SHALL hold the field encodings, the field widths and offsets, FRAME_BITS, the SYNC_WORD default and the FSM state typedef.
REQ-029 Sub-module xc20xx_cfg_check SHALL be purely combinational: payload plus parity in, accept/reject and decoded fields out.

Verification
REQ-030 Reset: assert R -> all outputs 0 and BUSY=0.
REQ-031 Valid frame: feed bits 11110001, then F2, then payload 96,3C,1,01,10,01,1,10, then parity 0 -> two edges after parity, F_INIT=96, G_INIT=3C, MUX_FG=1, S_IN=01, CLK_IN=10, CLK_POL=01, MODE=1, R_IN=10, one CFG_DONE pulse, CFG_VALID=1.
REQ-032 Same frame with parity 1 after a prior valid load -> one CFG_ERR pulse, outputs still hold the prior values, FSM in HUNT.
REQ-033 Frame with CLK_IN=11 and correct parity -> CFG_ERR pulse, outputs unchanged.
REQ-034 REQ-031 stimulus with DVALID=0 for 3 cycles between every bit -> identical final outputs.
REQ-035 Reset pulsed at payload bit 10, then the REQ-031 frame replayed -> no pulse from the aborted frame, then a normal accept.

Source files
------------

// File: rtl/xc20xx_cfg_pkg.sv
// Shared definitions for the XC20xx CLB configuration loader.
//   - Frame geometry (payload length, default sync pattern)
//   - Field widths/offsets inside the 26-bit payload (payload[25] is the
//     first bit received, i.e. the MSB of F_INIT)
//   - Field encodings as enums, the decoded-config struct and the FSM states
package xc20xx_cfg_pkg;

  localparam int          CFG_FRAME_BITS = 26;
  localparam logic [7:0]  CFG_SYNC_WORD  = 8'hF2;

  // Field widths, in transmission order.
  localparam int F_INIT_W  = 8;
  localparam int G_INIT_W  = 8;
  localparam int MUX_FG_W  = 1;
  localparam int S_IN_W    = 2;
  localparam int CLK_IN_W  = 2;
  localparam int CLK_POL_W = 2;
  localparam int MODE_W    = 1;
  localparam int R_IN_W    = 2;

  // Bit offsets (LSB position) inside the payload register.
  localparam int R_IN_OFS    = 0;
  localparam int MODE_OFS    = R_IN_OFS    + R_IN_W;
  localparam int CLK_POL_OFS = MODE_OFS    + MODE_W;
  localparam int CLK_IN_OFS  = CLK_POL_OFS + CLK_POL_W;
  localparam int S_IN_OFS    = CLK_IN_OFS  + CLK_IN_W;
  localparam int MUX_FG_OFS  = S_IN_OFS    + S_IN_W;
  localparam int G_INIT_OFS  = MUX_FG_OFS  + MUX_FG_W;
  localparam int F_INIT_OFS  = G_INIT_OFS  + G_INIT_W;

  typedef enum logic [1:0] {S_IN_A = 2'b00, S_IN_F = 2'b01, S_IN_NONE = 2'b10, S_IN_RSVD = 2'b11} s_in_e;
  typedef enum logic [1:0] {CLK_IN_K = 2'b00, CLK_IN_C = 2'b01, CLK_IN_G = 2'b10, CLK_IN_RSVD = 2'b11} clk_in_e;
  typedef enum logic [1:0] {CLK_POL_POSITIVE = 2'b00, CLK_POL_NEGATIVE = 2'b01, CLK_POL_NONE = 2'b10,
                            CLK_POL_RSVD = 2'b11} clk_pol_e;
  typedef enum logic      {MODE_DFF = 1'b0, MODE_DLATCH = 1'b1} mode_e;
  typedef enum logic [1:0] {R_IN_D = 2'b00, R_IN_F = 2'b01, R_IN_NONE = 2'b10, R_IN_RSVD = 2'b11} r_in_e;

  // Decoded configuration; all-zero is the A/K/POSITIVE/DFF/D default.
  typedef struct packed {
    logic [F_INIT_W-1:0] f_init;
    logic [G_INIT_W-1:0] g_init;
    logic                mux_fg;
    s_in_e               s_in;
    clk_in_e             clk_in;
    clk_pol_e            clk_pol;
    mode_e               mode;
    r_in_e               r_in;
  } clb_cfg_t;

  typedef enum logic [1:0] {ST_HUNT = 2'b00, ST_LOAD = 2'b01, ST_CHECK = 2'b10} cfg_state_e;

  // Code 11 is reserved in every 2-bit field.
  function automatic logic is_reserved(input logic [1:0] code);
    return code == 2'b11;
  endfunction

endpackage

// File: rtl/xc20xx_cfg_check.sv
// Combinational frame checker / decoder.
//   payload : 26 received payload bits (payload[25] received first)
//   parity  : received parity bit (even parity over payload + parity)
//   accept  : 1 when parity is good and no 2-bit field holds a reserved code
//   cfg     : payload split into typed configuration fields
module xc20xx_cfg_check
  import xc20xx_cfg_pkg::*;
(
  input  logic [CFG_FRAME_BITS-1:0] payload,
  input  logic                      parity,
  output logic                      accept,
  output clb_cfg_t                  cfg
);

  logic parity_ok;
  logic any_rsvd;

  always_comb begin
    cfg         = '0;
    cfg.f_init  = payload[F_INIT_OFS +: F_INIT_W];
    cfg.g_init  = payload[G_INIT_OFS +: G_INIT_W];
    cfg.mux_fg  = payload[MUX_FG_OFS];
    cfg.s_in    = s_in_e'(payload[S_IN_OFS +: S_IN_W]);
    cfg.clk_in  = clk_in_e'(payload[CLK_IN_OFS +: CLK_IN_W]);
    cfg.clk_pol = clk_pol_e'(payload[CLK_POL_OFS +: CLK_POL_W]);
    cfg.mode    = mode_e'(payload[MODE_OFS]);
    cfg.r_in    = r_in_e'(payload[R_IN_OFS +: R_IN_W]);

    parity_ok = ~(^payload ^ parity);
    any_rsvd  = is_reserved(payload[S_IN_OFS +: S_IN_W])
              | is_reserved(payload[CLK_IN_OFS +: CLK_IN_W])
              | is_reserved(payload[CLK_POL_OFS +: CLK_POL_W])
              | is_reserved(payload[R_IN_OFS +: R_IN_W]);
    accept    = parity_ok & ~any_rsvd;
  end

endmodule

// File: rtl/xc20xx_clb_cfg_loader.sv
// Serial configuration loader for one XC20xx-style CLB.
// Hunts for SYNC_WORD on the DIN/DVALID stream, shifts in a 26-bit payload
// and one parity bit, then spends one CHECK cycle deciding accept/reject.
//   K, R               : clock (rising edge), async active-high reset
//   DIN, DVALID        : serial data MSB first; a bit is taken only when DVALID=1
//   F_INIT..R_IN       : last accepted configuration (registered)
//   CFG_VALID          : a configuration has been accepted since reset
//   CFG_DONE / CFG_ERR : one-cycle accept / reject pulses, visible the cycle
//                        after CHECK (two edges after the parity bit edge)
//   BUSY               : frame in progress (LOAD or CHECK)
//   fsm_state          : current FSM state, for observation
// Handshake: DVALID is a qualifier only (no back-pressure); a bit is consumed
// on every rising edge where DVALID=1 in HUNT/LOAD, and dropped in CHECK.
module xc20xx_clb_cfg_loader
  import xc20xx_cfg_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD  = CFG_SYNC_WORD,
  parameter int         FRAME_BITS = CFG_FRAME_BITS
) (
  input  logic       K,
  input  logic       R,
  input  logic       DIN,
  input  logic       DVALID,
  output logic [7:0] F_INIT,
  output logic [7:0] G_INIT,
  output logic       MUX_FG,
  output logic [1:0] S_IN,
  output logic [1:0] CLK_IN,
  output logic [1:0] CLK_POL,
  output logic       MODE,
  output logic [1:0] R_IN,
  output logic       CFG_VALID,
  output logic       CFG_DONE,
  output logic       CFG_ERR,
  output logic       BUSY,
  output cfg_state_e fsm_state
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  cfg_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            win_q, win_d;
  logic [FRAME_BITS-1:0] payload_q, payload_d;
  logic                  parity_q, parity_d;

  clb_cfg_t cfg_q;
  logic     valid_q, done_q, err_q;

  logic     chk_accept;
  clb_cfg_t chk_cfg;

  xc20xx_cfg_check u_check (
    .payload (payload_q),
    .parity  (parity_q),
    .accept  (chk_accept),
    .cfg     (chk_cfg)
  );

  // Next-state logic. The counter reaches FRAME_BITS once all payload bits
  // are in; the following accepted bit is the parity bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    payload_d = payload_q;
    parity_d  = parity_q;
    unique case (state_q)
      ST_HUNT: begin
        if (DVALID) begin
          win_d = {win_q[6:0], DIN};
          if (win_d == SYNC_WORD) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end
        end
      end
      ST_LOAD: begin
        // The sync window is frozen here, so payload bits can never
        // re-trigger synchronisation.
        if (DVALID) begin
          if (cnt_q == CNT_W'(FRAME_BITS)) begin
            parity_d = DIN;
            state_d  = ST_CHECK;
          end else begin
            payload_d = {payload_q[FRAME_BITS-2:0], DIN};
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_CHECK: begin
        // DIN is ignored here; the next frame's sync starts from a clean window.
        state_d = ST_HUNT;
        win_d   = '0;
      end
      default: begin
        state_d = ST_HUNT;
        win_d   = '0;
      end
    endcase
  end

  always_ff @(posedge K or posedge R) begin
    if (R) begin
      state_q   <= ST_HUNT;
      cnt_q     <= '0;
      win_q     <= '0;
      payload_q <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      payload_q <= payload_d;
      parity_q  <= parity_d;
    end
  end

  // Result registers: updated on the edge that ends CHECK.
  always_ff @(posedge K or posedge R) begin
    if (R) begin
      cfg_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= (state_q == ST_CHECK) &&  chk_accept;
      err_q  <= (state_q == ST_CHECK) && !chk_accept;
      if ((state_q == ST_CHECK) && chk_accept) begin
        cfg_q   <= chk_cfg;
        valid_q <= 1'b1;
      end
    end
  end

  assign F_INIT    = cfg_q.f_init;
  assign G_INIT    = cfg_q.g_init;
  assign MUX_FG    = cfg_q.mux_fg;
  assign S_IN      = cfg_q.s_in;
  assign CLK_IN    = cfg_q.clk_in;
  assign CLK_POL   = cfg_q.clk_pol;
  assign MODE      = cfg_q.mode;
  assign R_IN      = cfg_q.r_in;
  assign CFG_VALID = valid_q;
  assign CFG_DONE  = done_q;
  assign CFG_ERR   = err_q;
  assign BUSY      = (state_q != ST_HUNT);
  assign fsm_state = state_q;

endmodule
